aes_encrypt_iter: RTL and testbench

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_round.sv | 51 +++++
 rtl/aes_encrypt_iter.sv | 110 +++++++++++
 tb/tb_aes_encrypt_iter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES encryption core.
// Contents:
//   aes_state_e        - controller states (IDLE / RUN / DONE)
//   NR_AES128/192/256  - legal round counts
//   nr_is_legal()      - elaboration-time check of the round count
//   SBOX / sbox()      - forward S-box table and lookup
//   xtime()            - multiply-by-x in GF(2^8), polynomial 0x11B
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  function automatic bit nr_is_legal(input int nr);
    return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
  endfunction

  // Element 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Shift left one bit; fold the carried-out x^8 term back as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round.
// Ports:
//   state_i [127:0] - current state, bits [127:120] = byte 0, column-major
//   rk_i    [127:0] - round key for this round
//   last_i          - final round: MixColumns is skipped
//   state_o [127:0] - state after SubBytes, ShiftRows, (MixColumns), AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] pre_key;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_i[127-8*i -: 8]);
    end

    // Byte index is 4*col + row; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end

    // Each output byte: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], with 3*a = xtime(a) ^ a.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mc[4*c+r] = xtime(sr[4*c+r])
                  ^ xtime(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                  ^ sr[4*c+(r+2)%4]
                  ^ sr[4*c+(r+3)%4];
      end
    end

    pre_key = '0;
    for (int i = 0; i < 16; i++) begin
      pre_key[127-8*i -: 8] = last_i ? sr[i] : mc[i];
    end

    state_o = pre_key ^ rk_i;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES block encryptor: one round per clock, round keys fetched
// from an external combinational key-schedule store.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   in_data/in_valid/in_ready    - plaintext input handshake
//   rk_addr / rk_data            - round-key request and same-cycle key
//   out_data/out_valid/out_ready - ciphertext output handshake
//   busy             - high while rounds are being computed
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [RK_AW-1:0] rk_addr,
  input  logic [127:0]     rk_data,
  output logic [127:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  if (!nr_is_legal(NR) || ((2 ** RK_AW) <= NR)) begin : g_bad_cfg
    $error("aes_encrypt_iter: illegal NR/RK_AW combination");
  end

  localparam logic [RK_AW-1:0] NR_CNT  = RK_AW'(NR);
  localparam logic [RK_AW-1:0] RND_ONE = RK_AW'(1);

  aes_state_e       st_q, st_d;
  logic [RK_AW-1:0] rnd_q, rnd_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     round_out;
  logic             accept;
  logic             last_round;

  assign last_round = (rnd_q == NR_CNT);

  aes_round u_round (
    .state_i (data_q),
    .rk_i    (rk_data),
    .last_i  (last_round),
    .state_o (round_out)
  );

  always_comb begin
    st_d     = st_q;
    rnd_d    = rnd_q;
    data_d   = data_q;
    rk_addr  = '0;
    in_ready = (st_q == ST_IDLE) || ((st_q == ST_DONE) && out_ready);
    accept   = in_valid && in_ready;

    unique case (st_q)
      ST_IDLE: begin
        // rk_addr is 0 here, so rk_data is the whitening key.
        if (accept) begin
          data_d = in_data ^ rk_data;
          rnd_d  = RND_ONE;
          st_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_addr = rnd_q;
        data_d  = round_out;
        if (last_round) begin
          rnd_d = '0;
          st_d  = ST_DONE;
        end else begin
          rnd_d = rnd_q + RND_ONE;
        end
      end
      ST_DONE: begin
        // Handshake and a new accept may share one edge: reload directly.
        if (out_ready) begin
          if (accept) begin
            data_d = in_data ^ rk_data;
            rnd_d  = RND_ONE;
            st_d   = ST_RUN;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      rnd_q  <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (st_q == ST_DONE);
  assign busy      = (st_q == ST_RUN);

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Testbench for aes_encrypt_iter: byte-array AES reference model with an
// algorithmically derived S-box, a per-cycle timing model for the NR=10
// instance, and directed runs of NR=12 / NR=14 instances.
module tb_aes_encrypt_iter;

  localparam int NR = 10;

  typedef logic [127:0] rk_arr_t [0:15];

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  logic [127:0] pt_c;
  logic         in_valid_x;
  logic         in_ready_12, in_ready_14;
  logic [3:0]   rk_addr_12, rk_addr_14;
  logic [127:0] rk_data_12, rk_data_14;
  logic [127:0] out_data_12, out_data_14;
  logic         out_valid_12, out_valid_14;
  logic         busy_12, busy_14;

  rk_arr_t ks, ks12, ks14;
  logic [7:0] sb_m [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign rk_data    = ks[rk_addr];
  assign rk_data_12 = ks12[rk_addr_12];
  assign rk_data_14 = ks14[rk_addr_14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_encrypt_iter #(.NR(10), .RK_AW(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rk_addr(rk_addr), .rk_data(rk_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  aes_encrypt_iter #(.NR(12), .RK_AW(4)) dut12 (
    .clk(clk), .rst(rst), .in_data(pt_c), .in_valid(in_valid_x),
    .in_ready(in_ready_12), .rk_addr(rk_addr_12), .rk_data(rk_data_12),
    .out_data(out_data_12), .out_valid(out_valid_12), .out_ready(1'b1), .busy(busy_12)
  );

  aes_encrypt_iter #(.NR(14), .RK_AW(4)) dut14 (
    .clk(clk), .rst(rst), .in_data(pt_c), .in_valid(in_valid_x),
    .in_ready(in_ready_14), .rk_addr(rk_addr_14), .rk_data(rk_data_14),
    .out_data(out_data_14), .out_valid(out_valid_14), .out_ready(1'b1), .busy(busy_14)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [255:0] key, input int nk, output rk_arr_t rks);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      rks[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input rk_arr_t rks, input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rks[0][127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sb_m[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < nr)
            s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03)
                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ rks[rd][127-8*(4*c+r) -: 8];
        end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- per-cycle compare against the timing model ----------------
  bit           chk_en = 0;
  int           m_left = 0;
  bit           m_done = 0;
  logic [127:0] m_out = '0;
  logic [127:0] m_pend = '0;
  int           n_hs = 0;
  bit           running, exp_rdy, acc;

  always @(negedge clk) begin
    running = (m_left > 0);
    exp_rdy = !running && (!m_done || out_ready);
    if (chk_en) begin
      check("in_ready", 128'(in_ready), 128'(exp_rdy));
      check("out_valid", 128'(out_valid), 128'(m_done));
      check("busy", 128'(busy), 128'(running));
      check("rk_addr", 128'(rk_addr), running ? 128'(NR - m_left + 1) : 128'h0);
      if (m_done) check("out_data", out_data, m_out);
    end
    if (rst) begin
      m_left = 0;
      m_done = 0;
      chk_en = 1;
    end else if (chk_en) begin
      acc = in_valid && exp_rdy;
      if (running) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_out  = m_pend;
        end
      end else if (m_done && out_ready) begin
        m_done = 0;
        n_hs++;
      end
      if (acc) begin
        m_pend = model_enc(in_data, ks, NR);
        m_left = NR;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    bit ok;
    ok = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 1'b0;
    in_data  = rand128();
    check("send_accepted", 128'(ok), 128'h1);
  endtask

  task automatic wait_out(output int lat, output logic [127:0] d);
    lat = 0;
    d   = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        d   = out_data;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!busy && !out_valid) ok = 1;
      tick();
    end
    check("drain_idle", 128'(ok), 128'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int lat, lat12, lat14, hs0, n;
    int acc_c [4];
    logic [127:0] d, d12, d14, b;
    rk_arr_t tmp;

    rst = 1'b1;
    in_valid = 1'b0;
    in_valid_x = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    pt_c = PT_STD;

    build_sbox();
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, tmp);
    check("model_fips_b", model_enc(128'h3243f6a8885a308d313198a2e0370734, tmp, 10),
          128'h3925841d02dc09fbdc118597196a0b32);
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, tmp);
    check("model_aes128", model_enc(PT_STD, tmp, 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, ks12);
    check("model_aes192", model_enc(PT_STD, ks12, 12), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, ks14);
    check("model_aes256", model_enc(PT_STD, ks14, 14), 128'h8ea2b7ca516745bfeafc49904b496089);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_data", out_data, 128'h0);

    // FIPS-197 appendix B vector with latency
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, ks);
    send(128'h3243f6a8885a308d313198a2e0370734);
    wait_out(lat, d);
    check("fips_b_latency", 128'(lat), 128'(NR + 1));
    check("fips_b_data", d, 128'h3925841d02dc09fbdc118597196a0b32);
    wait_idle();

    // AES-128 appendix C vector with output stall
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, ks);
    out_ready = 1'b0;
    send(PT_STD);
    wait_out(lat, d);
    check("aes128_data", d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = rand128();
      tick();
    end
    in_valid = 1'b0;
    hs0 = n_hs;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_still_valid", 128'(out_valid), 128'h1);
    check("stall_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();
    @(negedge clk);
    check("stall_released", 128'(out_valid), 128'h0);
    check("stall_single_hs", 128'(n_hs - hs0), 128'h1);
    tick();

    // NR=12 and NR=14 instances
    in_valid_x = 1'b1;
    @(negedge clk);
    check("rdy12", 128'(in_ready_12), 128'h1);
    check("rdy14", 128'(in_ready_14), 128'h1);
    tick();
    in_valid_x = 1'b0;
    lat12 = 0; lat14 = 0; d12 = '0; d14 = '0;
    for (int k = 1; k <= 40 && (lat12 == 0 || lat14 == 0); k++) begin
      @(negedge clk);
      if (out_valid_12 && lat12 == 0) begin lat12 = k; d12 = out_data_12; end
      if (out_valid_14 && lat14 == 0) begin lat14 = k; d14 = out_data_14; end
    end
    tick();
    check("aes192_latency", 128'(lat12), 128'd13);
    check("aes192_data", d12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    check("aes256_latency", 128'(lat14), 128'd15);
    check("aes256_data", d14, 128'h8ea2b7ca516745bfeafc49904b496089);

    // back-to-back: in_valid held high across four blocks
    expand({rand128(), 128'h0}, 4, ks);
    hs0 = n_hs;
    n = 0;
    b = rand128();
    in_data = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        acc_c[n] = cyc;
        n++;
        in_data = rand128();
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(n), 128'd4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 128'(acc_c[i] - acc_c[i-1]), 128'(NR + 1));
    wait_idle();
    check("b2b_outputs", 128'(n_hs - hs0), 128'd4);

    // randomized traffic, key changed only while idle
    for (int p = 0; p < 3; p++) begin
      expand({rand128(), 128'h0}, 4, ks);
      for (int k = 0; k < 300; k++) begin
        in_valid  = ($urandom_range(0, 2) == 0);
        in_data   = rand128();
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      wait_idle();
    end

    // reset in the middle of round 5
    send(rand128());
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'h0);
    check("midrst_in_ready", 128'(in_ready), 128'h1);
    check("midrst_out_data", out_data, 128'h0);
    tick();
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, ks);
    send(PT_STD);
    wait_out(lat, d);
    check("after_rst_latency", 128'(lat), 128'(NR + 1));
    check("after_rst_data", d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
